// File: rtl/ins_decode_stage.sv
// Instruction decode stage: classifies a 32-bit uPower instruction, unpacks it into a
// unified sign-extended record, and buffers records in a small flushable FIFO.
module ins_decode_stage #(
  parameter int PC_WIDTH = 32,
  parameter int DEPTH    = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instruction,
  input  logic [PC_WIDTH-1:0]   p_count,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [2:0]            fmt,
  output logic                  illegal,
  output logic [5:0]            opcode,
  output logic [4:0]            rd,
  output logic [4:0]            rt,
  output logic [4:0]            rs,
  output logic [9:0]            xo,
  output logic [31:0]           imm,
  output logic                  aa,
  output logic                  lk,
  output logic                  rc,
  output logic                  oe,
  output logic [PC_WIDTH-1:0]   pc_out,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  localparam logic [2:0] FMT_XO  = 3'd0;
  localparam logic [2:0] FMT_X   = 3'd1;
  localparam logic [2:0] FMT_D   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_I   = 3'd4;
  localparam logic [2:0] FMT_DS  = 3'd5;
  localparam logic [2:0] FMT_ILL = 3'd7;

  typedef struct packed {
    logic [2:0]          fmt;
    logic                illegal;
    logic [5:0]          opcode;
    logic [4:0]          rd;
    logic [4:0]          rt;
    logic [4:0]          rs;
    logic [9:0]          xo;
    logic [31:0]         imm;
    logic                aa;
    logic                lk;
    logic                rc;
    logic                oe;
    logic [PC_WIDTH-1:0] pc;
  } rec_t;

  logic [5:0] op;
  logic       is_xo_sub;
  logic       is_d_op;
  rec_t       dec;

  assign op = instruction[31:26];

  always_comb begin
    is_xo_sub = 1'b0;
    case (instruction[9:1])
      9'd266, 9'd40, 9'd235, 9'd491: is_xo_sub = 1'b1;
      default:                       is_xo_sub = 1'b0;
    endcase
  end

  always_comb begin
    is_d_op = 1'b0;
    case (op)
      6'd14, 6'd15, 6'd24, 6'd26, 6'd28, 6'd32, 6'd34,
      6'd36, 6'd37, 6'd38, 6'd40, 6'd42, 6'd44: is_d_op = 1'b1;
      default:                                 is_d_op = 1'b0;
    endcase
  end

  // Anything not matched keeps the illegal defaults: only opcode and pc survive.
  always_comb begin
    dec         = '0;
    dec.opcode  = op;
    dec.pc      = p_count;
    dec.fmt     = FMT_ILL;
    dec.illegal = 1'b1;
    if (op == 6'd31) begin
      dec.illegal = 1'b0;
      dec.rd      = instruction[25:21];
      dec.rt      = instruction[20:16];
      dec.rs      = instruction[15:11];
      dec.rc      = instruction[0];
      if (is_xo_sub) begin
        dec.fmt = FMT_XO;
        dec.xo  = {1'b0, instruction[9:1]};
        dec.oe  = instruction[10];
      end else begin
        dec.fmt = FMT_X;
        dec.xo  = instruction[10:1];
      end
    end else if (is_d_op) begin
      dec.illegal = 1'b0;
      dec.fmt     = FMT_D;
      dec.rd      = instruction[25:21];
      dec.rt      = instruction[20:16];
      dec.imm     = {{16{instruction[15]}}, instruction[15:0]};
    end else if (op == 6'd19) begin
      dec.illegal = 1'b0;
      dec.fmt     = FMT_B;
      dec.rd      = instruction[25:21];
      dec.rt      = instruction[20:16];
      dec.imm     = {{16{instruction[15]}}, instruction[15:2], 2'b00};
      dec.aa      = instruction[1];
      dec.lk      = instruction[0];
    end else if (op == 6'd18) begin
      dec.illegal = 1'b0;
      dec.fmt     = FMT_I;
      dec.imm     = {{6{instruction[25]}}, instruction[25:2], 2'b00};
      dec.aa      = instruction[1];
      dec.lk      = instruction[0];
    end else if (op == 6'd58 || op == 6'd62) begin
      dec.illegal = 1'b0;
      dec.fmt     = FMT_DS;
      dec.rd      = instruction[25:21];
      dec.rt      = instruction[20:16];
      dec.imm     = {{16{instruction[15]}}, instruction[15:2], 2'b00};
      dec.xo      = {8'b0, instruction[1:0]};
    end
  end

  rec_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          push;
  logic          pop;
  rec_t          head;

  assign in_ready  = (count < CW'(DEPTH)) & ~flush & ~rst;
  assign out_valid = (count != '0);
  assign push      = in_valid & in_ready;
  // A pop in a flush cycle is void; flush already clears everything.
  assign pop       = out_valid & out_ready & ~flush;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= dec;
  end

  assign head    = out_valid ? mem[rd_ptr] : '0;
  assign fmt     = head.fmt;
  assign illegal = head.illegal;
  assign opcode  = head.opcode;
  assign rd      = head.rd;
  assign rt      = head.rt;
  assign rs      = head.rs;
  assign xo      = head.xo;
  assign imm     = head.imm;
  assign aa      = head.aa;
  assign lk      = head.lk;
  assign rc      = head.rc;
  assign oe      = head.oe;
  assign pc_out  = head.pc;

endmodule
